// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/load-store masters, the shared memory
// slave, and the arbiter. The slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  m0_req_i;
  logic [ADDR_W-1:0]     m0_addr_i;
  logic [DATA_W-1:0]     m0_rdata_o;
  logic                  m0_ack_o;
  logic                  m1_req_i;
  logic                  m1_we_i;
  logic [ADDR_W-1:0]     m1_addr_i;
  logic [DATA_W-1:0]     m1_wdata_i;
  logic [DATA_W/8-1:0]   m1_wstrb_i;
  logic [DATA_W-1:0]     m1_rdata_o;
  logic                  m1_ack_o;
  logic                  s_req_o;
  logic                  s_we_o;
  logic [ADDR_W-1:0]     s_addr_o;
  logic [DATA_W-1:0]     s_wdata_o;
  logic [DATA_W/8-1:0]   s_wstrb_o;
  logic                  s_ack_i;
  logic [DATA_W-1:0]     s_rdata_i;
  logic                  hold_flag_o;
  logic                  err_o;

  modport slave (
    input  m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
           m1_wstrb_i, s_ack_i, s_rdata_i,
    output m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, s_req_o, s_we_o,
           s_addr_o, s_wdata_o, s_wstrb_o, hold_flag_o, err_o
  );

  modport master (
    output m0_req_i, m0_addr_i, m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
           m1_wstrb_i, s_ack_i, s_rdata_i,
    input  m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, s_req_o, s_we_o,
           s_addr_o, s_wdata_o, s_wstrb_o, hold_flag_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-ported memory slave: load/store has priority,
// fetch is protected by a starvation limit, and stalled slave accesses time out.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

  state_t              state;
  logic [SC_W-1:0]     starve_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                s_req_q, s_we_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [STRB_W-1:0]   s_wstrb_q;
  logic                m0_ack_q, m1_ack_q, err_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
  logic                m0_pend, m1_pend, grant_m1, grant_m0, timed_out;

  // A master being acked this cycle is masked so its held req is not re-granted.
  always_comb begin
    m0_pend   = bus.m0_req_i & ~m0_ack_q;
    m1_pend   = bus.m1_req_i & ~m1_ack_q;
    grant_m1  = m1_pend & (~m0_pend | (starve_cnt != SC_W'(STARVE_LIMIT)));
    grant_m0  = m0_pend & ~grant_m1;
    timed_out = (to_cnt == TO_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      s_req_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_m1) begin
            state     <= BUSY_M1;
            s_req_q   <= 1'b1;
            s_we_q    <= bus.m1_we_i;
            s_addr_q  <= bus.m1_addr_i;
            s_wdata_q <= bus.m1_wdata_i;
            s_wstrb_q <= bus.m1_wstrb_i;
            to_cnt    <= '0;
            if (!bus.m0_req_i)
              starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_LIMIT))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_m0) begin
            state      <= BUSY_M0;
            s_req_q    <= 1'b1;
            s_we_q     <= 1'b0;
            s_addr_q   <= bus.m0_addr_i;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '1;
            to_cnt     <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_M0, BUSY_M1: begin
          // A slave ack in the timeout cycle wins over the abort.
          if (bus.s_ack_i || timed_out) begin
            state   <= IDLE;
            s_req_q <= 1'b0;
            err_q   <= ~bus.s_ack_i;
            if (state == BUSY_M0) begin
              m0_ack_q   <= 1'b1;
              m0_rdata_q <= bus.s_ack_i ? bus.s_rdata_i : '0;
            end else begin
              m1_ack_q   <= 1'b1;
              m1_rdata_q <= (bus.s_ack_i && !s_we_q) ? bus.s_rdata_i : '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_req_o     = s_req_q;
    bus.s_we_o      = s_we_q;
    bus.s_addr_o    = s_addr_q;
    bus.s_wdata_o   = s_wdata_q;
    bus.s_wstrb_o   = s_wstrb_q;
    bus.m0_ack_o    = m0_ack_q;
    bus.m1_ack_o    = m1_ack_q;
    bus.m0_rdata_o  = m0_rdata_q;
    bus.m1_rdata_o  = m1_rdata_q;
    bus.err_o       = err_q;
    bus.hold_flag_o = m0_pend | m1_pend;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level reference of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int unsigned SL = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference: who owns the slave (0 none, 1 fetch, 2 load/store), the latched
  // transaction, how long it has waited, and what each master sees this cycle.
  int unsigned owner = 0, age = 0, starve = 0;
  logic        t_we = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0, e_rd0 = '0, e_rd1 = '0;
  logic [3:0]  t_wstrb = '0;
  logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_err = 1'b0;

  logic [137:0] dut_obs, exp_obs;
  always_comb begin
    dut_obs = {bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o,
               bus.m0_ack_o, bus.m0_rdata_o, bus.m1_ack_o, bus.m1_rdata_o,
               bus.err_o, bus.hold_flag_o};
    exp_obs = {owner != 0, t_we, t_addr, t_wdata, t_wstrb, e_ack0, e_rd0, e_ack1, e_rd1,
               e_err, (bus.m0_req_i && !e_ack0) || (bus.m1_req_i && !e_ack1)};
  end

  task automatic model_step();
    logic a0, a1, p0, p1;
    logic [31:0] d;
    if (rst) begin
      owner = 0; age = 0; starve = 0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
      t_wstrb = '0; e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      a0 = e_ack0; a1 = e_ack1;
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0;
      if (owner != 0) begin
        if (bus.s_ack_i || age == TO) begin
          d = (bus.s_ack_i && !t_we) ? bus.s_rdata_i : 32'h0;
          e_err = !bus.s_ack_i;
          if (owner == 1) begin e_ack0 = 1'b1; e_rd0 = d; end
          else begin e_ack1 = 1'b1; e_rd1 = d; end
          owner = 0;
        end else age++;
      end else begin
        p0 = bus.m0_req_i && !a0;
        p1 = bus.m1_req_i && !a1;
        if (p1 && !(p0 && starve == SL)) begin
          owner = 2; age = 0;
          t_we = bus.m1_we_i; t_addr = bus.m1_addr_i;
          t_wdata = bus.m1_wdata_i; t_wstrb = bus.m1_wstrb_i;
          starve = bus.m0_req_i ? ((starve < SL) ? starve + 1 : starve) : 0;
        end else if (p0) begin
          owner = 1; age = 0; starve = 0;
          t_we = 1'b0; t_addr = bus.m0_addr_i; t_wdata = '0; t_wstrb = 4'hF;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic m0r, input logic [31:0] m0a,
                       input logic m1r, input logic m1w, input logic [31:0] m1a,
                       input logic [31:0] m1d, input logic [3:0] m1s,
                       input logic sa, input logic [31:0] sd);
    rst = r;
    bus.m0_req_i = m0r; bus.m0_addr_i = m0a;
    bus.m1_req_i = m1r; bus.m1_we_i = m1w; bus.m1_addr_i = m1a;
    bus.m1_wdata_i = m1d; bus.m1_wstrb_i = m1s;
    bus.s_ack_i = sa; bus.s_rdata_i = sd;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, owner != 0, 32'h0BAD_0001);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    checks++;
    if (dut_obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", dut_obs); end
    checks++;
    if (dut_obs !== exp_obs) begin failures++; $display("FAIL reset_model got=%h exp=%h", dut_obs, exp_obs); end
    tick();
  endtask

  task automatic test_single_fetch();
    for (int c = 0; c <= 4; c++) begin
      drive(1'b0, c <= 3, 32'h100, 1'b0, 1'b0, '0, '0, '0, c == 2, 32'hDEADBEEF);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL fetch_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      checks++;
      if ({bus.s_req_o, bus.hold_flag_o} !== {c == 1 || c == 2, c <= 2}) begin
        failures++; $display("FAIL fetch_req_hold c%0d got=%b%b", c, bus.s_req_o, bus.hold_flag_o);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (bus.s_addr_o !== 32'h100) begin failures++; $display("FAIL fetch_addr c%0d got=%h exp=100", c, bus.s_addr_o); end
      end
      if (c == 3) begin
        checks++;
        if ({bus.m0_ack_o, bus.m0_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin
          failures++; $display("FAIL fetch_ack got=%b/%h exp=1/deadbeef", bus.m0_ack_o, bus.m0_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    for (int c = 0; c <= 5; c++) begin
      drive(1'b0, c <= 4, 32'h400, c <= 2, 1'b1, 32'h200, 32'h55AA, 4'h3,
            c == 1 || c == 3, 32'h12345678);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL contention_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      if (c == 1) begin
        checks++;
        if ({bus.s_req_o, bus.s_we_o, bus.s_wstrb_o, bus.s_addr_o, bus.s_wdata_o} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'h55AA}) begin
          failures++; $display("FAIL contention_m1_first got we=%b strb=%h addr=%h", bus.s_we_o, bus.s_wstrb_o, bus.s_addr_o);
        end
      end
      if (c == 2) begin
        checks++;
        if ({bus.m1_ack_o, bus.m0_ack_o, bus.m1_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
          failures++; $display("FAIL contention_m1_ack got=%b%b/%h exp=10/0", bus.m1_ack_o, bus.m0_ack_o, bus.m1_rdata_o);
        end
      end
      if (c == 3) begin
        checks++;
        if ({bus.s_req_o, bus.s_we_o, bus.s_wstrb_o, bus.s_addr_o, bus.s_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h400, 32'h0}) begin
          failures++; $display("FAIL contention_m0_grant got req=%b we=%b strb=%h addr=%h", bus.s_req_o, bus.s_we_o, bus.s_wstrb_o, bus.s_addr_o);
        end
      end
      if (c == 4) begin
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_rdata_o} !== {1'b1, 1'b0, 32'h12345678}) begin
          failures++; $display("FAIL contention_m0_ack got=%b%b/%h exp=10/12345678", bus.m0_ack_o, bus.m1_ack_o, bus.m0_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, '0, 4'hF, c % 2 == 1, 32'h0 + c);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL b2b_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      checks++;
      if ({bus.s_req_o, bus.m1_ack_o, bus.m0_ack_o} !== {c % 2 == 1, c % 4 == 2, c % 4 == 0 && c > 0}) begin
        failures++; $display("FAIL b2b_pattern c%0d got=%b%b%b", c, bus.s_req_o, bus.m1_ack_o, bus.m0_ack_o);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_starvation();
    int unsigned run = 0, max_run = 0, m0_grants = 0, prev;
    for (int c = 0; c < 80; c++) begin
      drive(1'b0, 1'b1, 32'h1000, 1'b1, 1'(c % 3 == 0), 32'h2000, 32'h0 + c, 4'hF,
            owner != 0 && $urandom_range(0, 1) == 1, $urandom);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL starve_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      prev = owner;
      tick();
      if (prev == 0 && owner == 2) begin run++; if (run > max_run) max_run = run; end
      if (prev == 0 && owner == 1) begin run = 0; m0_grants++; end
    end
    checks++;
    if (max_run > SL || m0_grants == 0) begin
      failures++; $display("FAIL starve_limit got run=%0d m0_grants=%0d exp run<=%0d grants>0", max_run, m0_grants, SL);
    end
    drain();
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 38; c++) begin
      drive(1'b0, 1'b0, '0, c <= 37, 1'b0, c < 19 ? 32'h500 : 32'h504, '0, 4'hF,
            c == 19 || c == 36, 32'hCAFE0001);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL timeout_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      if (c >= 1 && c <= 17) begin
        checks++;
        if ({bus.s_req_o, bus.m1_ack_o, bus.err_o} !== 3'b100) begin
          failures++; $display("FAIL timeout_wait c%0d got=%b%b%b exp=100", c, bus.s_req_o, bus.m1_ack_o, bus.err_o);
        end
      end
      if (c == 18) begin
        checks++;
        if ({bus.m1_ack_o, bus.m1_rdata_o, bus.err_o, bus.s_req_o} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
          failures++; $display("FAIL timeout_abort got ack=%b rd=%h err=%b req=%b", bus.m1_ack_o, bus.m1_rdata_o, bus.err_o, bus.s_req_o);
        end
      end
      if (c == 20) begin
        checks++;
        if ({bus.s_req_o, bus.s_addr_o} !== {1'b1, 32'h504}) begin
          failures++; $display("FAIL timeout_regrant got req=%b addr=%h exp=1/504", bus.s_req_o, bus.s_addr_o);
        end
      end
      if (c == 37) begin
        checks++;
        if ({bus.m1_ack_o, bus.err_o, bus.m1_rdata_o} !== {1'b1, 1'b0, 32'hCAFE0001}) begin
          failures++; $display("FAIL timeout_edge_ack got ack=%b err=%b rd=%h", bus.m1_ack_o, bus.err_o, bus.m1_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_field_stability();
    for (int c = 0; c <= 5; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0, c == 0 ? 32'h300 : 32'h304, 32'h0 + c, 4'h0 + c,
            c == 4, 32'hA5A5A5A5);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL field_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      if (c >= 1) begin
        checks++;
        if (bus.s_addr_o !== 32'h300) begin failures++; $display("FAIL field_addr c%0d got=%h exp=300", c, bus.s_addr_o); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 3; c++) begin
      drive(c == 1, c <= 1, 32'h700, 1'b0, 1'b0, '0, '0, '0, c == 2, 32'h77777777);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL rstmid_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      if (c >= 2) begin
        checks++;
        if ({bus.s_req_o, bus.m0_ack_o, bus.err_o, bus.m0_rdata_o} !== '0) begin
          failures++; $display("FAIL rstmid_quiet c%0d got req=%b ack=%b err=%b rd=%h", c, bus.s_req_o, bus.m0_ack_o, bus.err_o, bus.m0_rdata_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic r0 = 1'b0, r1 = 1'b0, sa = 1'b0, slow = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) slow = 1'($urandom_range(0, 1));
      if (!r0) r0 = ($urandom_range(0, 2) == 0); else if (e_ack0) r0 = 1'($urandom_range(0, 1));
      if (!r1) r1 = ($urandom_range(0, 2) == 0); else if (e_ack1) r1 = 1'($urandom_range(0, 1));
      if (sa) sa = 1'b0;
      else if (owner != 0) sa = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      else sa = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 99) == 0, r0, $urandom, r1, 1'($urandom_range(0, 1)), $urandom,
            $urandom, 4'($urandom_range(0, 15)), sa, $urandom);
      checks++;
      if (dut_obs !== exp_obs) begin failures++; $display("FAIL random_model c%0d got=%h exp=%h", c, dut_obs, exp_obs); end
      checks++;
      if ((bus.m0_ack_o && bus.m1_ack_o) || (bus.err_o && !(bus.m0_ack_o || bus.m1_ack_o))) begin
        failures++; $display("FAIL random_ack_excl c%0d got ack0=%b ack1=%b err=%b", c, bus.m0_ack_o, bus.m1_ack_o, bus.err_o);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.m0_req_i = 1'b0; bus.m0_addr_i = '0; bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m1_addr_i = '0; bus.m1_wdata_i = '0; bus.m1_wstrb_i = '0;
    bus.s_ack_i = 1'b0; bus.s_rdata_i = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_back_to_back();
    test_starvation();
    test_timeout();
    test_field_stability();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
